// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
// ----------------------------------------------------------------------------
// MEM-stage data access sequencer for the MIPS pipeline. Takes one qualified
// load/store from the MEM pipeline register, drives it onto the SRAM-like
// data bus (data_req / addr_ok / data_ok), stalls the pipeline until the
// access completes and returns registered load data.
//
// A flush (exception) that lands while a bus transaction is outstanding is
// absorbed: the request is never withdrawn before addr_ok, and a trailing
// data_ok is drained so it cannot be mistaken for the next access's reply.
//
// Optional feature (macro MEM_PERF_CNT_EN):
//   perf_stall_cycles - cycles with stall_req=1 (wraps mod 2^32)
//   perf_access_cnt   - completed accesses, counted in DONE (wraps mod 2^32)
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   exception           pipeline flush
//   mem_req_*           MEM-stage request (valid/wr/size/addr/wdata)
//   data_req/wr/size/addr/wdata   bus request (registered)
//   data_addr_ok, data_data_ok, data_rdata   bus responses
//   stall_req           hold PC..MEM stages (combinational)
//   load_data           registered read data
//   load_valid          one-cycle pulse in DONE for loads
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exception,
    input  logic              mem_req_valid,
    input  logic              mem_req_wr,
    input  logic [1:0]        mem_req_size,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_wdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              stall_req,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_access_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state;
    logic   flush_pend;   // exception seen while waiting for addr_ok
    logic   start;

    assign start = mem_req_valid && !exception;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            flush_pend <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wdata <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        data_wr    <= mem_req_wr;
                        data_size  <= mem_req_size;
                        data_addr  <= mem_req_addr;
                        data_wdata <= mem_req_wdata;
                        data_req   <= 1'b1;
                        flush_pend <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Request stays up until accepted; a flush only redirects
                    // the tail of the transaction into DRAIN.
                    if (data_addr_ok) begin
                        data_req   <= 1'b0;
                        flush_pend <= 1'b0;
                        state      <= (exception || flush_pend) ? S_DRAIN : S_WAIT;
                    end else if (exception) begin
                        flush_pend <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (exception) begin
                        // Flush beats a coincident data_ok: reply is complete,
                        // nothing left to drain.
                        state <= data_data_ok ? S_IDLE : S_DRAIN;
                    end else if (data_data_ok) begin
                        if (!data_wr) begin
                            load_data <= data_rdata;
                        end
                        load_valid <= !data_wr;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (data_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // DONE releases the stall for exactly one cycle so the pipeline advances
    // once per access; reset forces the stall low.
    always_comb begin
        stall_req = 1'b0;
        if (rst) begin
            case (state)
                S_IDLE:  stall_req = start;
                S_REQ,
                S_WAIT,
                S_DRAIN: stall_req = 1'b1;
                default: stall_req = 1'b0;
            endcase
        end
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= 32'd0;
            perf_access_cnt   <= 32'd0;
        end else begin
            if (stall_req) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (state == S_DONE) begin
                perf_access_cnt <= perf_access_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl
// ----------------------------------------------------------------------------
// Directed, cycle-by-cycle bench for mem_access_ctrl. Bus responses are
// driven by hand each cycle; expected values are written out per cycle.
// Inputs change at posedge+1, outputs are sampled one step later.
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception;
    logic        mem_req_valid;
    logic        mem_req_wr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stall_req;
    logic [31:0] load_data;
    logic        load_valid;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_access_cnt;
`endif

    int errs = 0;
    int nchk = 0;
    int hs_cnt = 0;
    int lv_cnt = 0;
    int h0, l0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .exception     (exception),
        .mem_req_valid (mem_req_valid),
        .mem_req_wr    (mem_req_wr),
        .mem_req_size  (mem_req_size),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .stall_req     (stall_req),
        .load_data     (load_data),
        .load_valid    (load_valid)
`ifdef MEM_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_access_cnt   (perf_access_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Count bus handshakes and load_valid pulses as seen at the clock edge.
    always @(posedge clk) begin
        if (data_req && data_addr_ok) hs_cnt <= hs_cnt + 1;
        if (load_valid) lv_cnt <= lv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        mem_req_valid = 1'b1;
        mem_req_wr    = wr;
        mem_req_size  = sz;
        mem_req_addr  = a;
        mem_req_wdata = wd;
    endtask

    // Zero-wait load: request c0, data_req+addr_ok c1, data_ok c2, DONE c3.
    // Returns at the start of the IDLE cycle after DONE.
    task automatic load_zw(input logic [31:0] a, input logic [31:0] rd);
        set_req(1'b0, 2'd2, a, 32'h0);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        #1;
        chk("lw_c0_stall", 32'(stall_req), 32'd1);
        chk("lw_c0_req", 32'(data_req), 32'd0);
        nxt();
        data_addr_ok = 1'b1;
        #1;
        chk("lw_c1_req", 32'(data_req), 32'd1);
        chk("lw_c1_addr", data_addr, a);
        chk("lw_c1_size", 32'(data_size), 32'd2);
        chk("lw_c1_wr", 32'(data_wr), 32'd0);
        chk("lw_c1_stall", 32'(stall_req), 32'd1);
        nxt();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rd;
        #1;
        chk("lw_c2_req", 32'(data_req), 32'd0);
        chk("lw_c2_stall", 32'(stall_req), 32'd1);
        chk("lw_c2_lv", 32'(load_valid), 32'd0);
        nxt();
        data_data_ok = 1'b0;
        #1;
        chk("lw_c3_stall", 32'(stall_req), 32'd0);
        chk("lw_c3_lv", 32'(load_valid), 32'd1);
        chk("lw_c3_data", load_data, rd);
        nxt();
    endtask

    initial begin
        rst           = 1'b0;
        exception     = 1'b0;
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b0;
        data_rdata    = 32'h0;
        set_req(1'b0, 2'd2, 32'h0000_1234, 32'h0);   // valid high: stall must still be 0
        #1;
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_lv", 32'(load_valid), 32'd0);
        chk("rst_ldata", load_data, 32'h0);
        chk("rst_addr", data_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mem_req_valid = 1'b0;
        nxt();

        // ---- load word, zero-wait bus ----
        load_zw(32'h0000_1000, 32'hDEAD_BEEF);
        mem_req_valid = 1'b0;
        #1;
        chk("lw_idle_lv", 32'(load_valid), 32'd0);
        chk("lw_idle_stall", 32'(stall_req), 32'd0);
        nxt();

        // ---- store byte, addr_ok after 4 wait cycles ----
        set_req(1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AA);
        #1;
        chk("sb_c0_stall", 32'(stall_req), 32'd1);
        nxt();
        for (int i = 0; i < 5; i++) begin
            data_addr_ok = (i == 4);
            #1;
            chk("sb_req", 32'(data_req), 32'd1);
            chk("sb_addr", data_addr, 32'h3);
            chk("sb_size", 32'(data_size), 32'd0);
            chk("sb_wr", 32'(data_wr), 32'd1);
            chk("sb_wdata", data_wdata, 32'hAA);
            chk("sb_lv", 32'(load_valid), 32'd0);
            nxt();
        end
        data_addr_ok = 1'b0;
        #1;
        chk("sb_wait_req", 32'(data_req), 32'd0);
        chk("sb_wait_stall", 32'(stall_req), 32'd1);
        nxt();
        data_data_ok = 1'b1;
        data_rdata   = 32'h0000_0099;
        #1;
        chk("sb_dok_stall", 32'(stall_req), 32'd1);
        nxt();
        data_data_ok = 1'b0;
        #1;
        chk("sb_done_stall", 32'(stall_req), 32'd0);
        chk("sb_done_lv", 32'(load_valid), 32'd0);
        chk("sb_done_ldata", load_data, 32'hDEAD_BEEF);
        mem_req_valid = 1'b0;
        nxt();
        #1;
        chk("sb_idle_lv", 32'(load_valid), 32'd0);

        // ---- exception during REQ: held until addr_ok, then drained ----
        set_req(1'b0, 2'd2, 32'h0000_0040, 32'h0);
        #1;
        nxt();
        exception = 1'b1;
        #1;
        chk("exr_c1_req", 32'(data_req), 32'd1);
        nxt();
        exception = 1'b0;
        mem_req_valid = 1'b0;
        #1;
        chk("exr_c2_req", 32'(data_req), 32'd1);
        chk("exr_c2_addr", data_addr, 32'h40);
        nxt();
        data_addr_ok = 1'b1;
        #1;
        chk("exr_c3_req", 32'(data_req), 32'd1);
        nxt();
        data_addr_ok = 1'b0;
        #1;
        chk("exr_drain_req", 32'(data_req), 32'd0);
        chk("exr_drain_stall", 32'(stall_req), 32'd1);
        nxt();
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_5555;
        #1;
        chk("exr_dok_stall", 32'(stall_req), 32'd1);
        nxt();
        data_data_ok = 1'b0;
        #1;
        chk("exr_idle_stall", 32'(stall_req), 32'd0);
        chk("exr_idle_lv", 32'(load_valid), 32'd0);
        chk("exr_ldata", load_data, 32'hDEAD_BEEF);
        nxt();

        // ---- exception coincident with data_ok in WAIT ----
        set_req(1'b0, 2'd2, 32'h0000_0080, 32'h0);
        #1;
        nxt();
        data_addr_ok = 1'b1;
        #1;
        nxt();
        data_addr_ok = 1'b0;
        exception    = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h7777_7777;
        #1;
        chk("exw_stall", 32'(stall_req), 32'd1);
        nxt();
        exception     = 1'b0;
        data_data_ok  = 1'b0;
        mem_req_valid = 1'b0;
        #1;
        chk("exw_idle_stall", 32'(stall_req), 32'd0);
        chk("exw_idle_lv", 32'(load_valid), 32'd0);
        chk("exw_ldata", load_data, 32'hDEAD_BEEF);
        nxt();
        load_zw(32'h0000_2000, 32'h1234_5678);
        mem_req_valid = 1'b0;
        nxt();

        // ---- back-to-back loads ----
        h0 = hs_cnt;
        l0 = lv_cnt;
        load_zw(32'h0000_0010, 32'h0000_0001);
        load_zw(32'h0000_0014, 32'h0000_0002);
        mem_req_valid = 1'b0;
        nxt();
        nxt();
        chk("b2b_handshakes", 32'(hs_cnt - h0), 32'd2);
        chk("b2b_lv_pulses", 32'(lv_cnt - l0), 32'd2);
        chk("b2b_ldata", load_data, 32'h0000_0002);
`ifdef MEM_PERF_CNT_EN
        chk("perf_access", perf_access_cnt, 32'd5);
`endif

        // ---- reset asserted while in WAIT ----
        set_req(1'b0, 2'd2, 32'h0000_0300, 32'h0);
        #1;
        nxt();
        data_addr_ok = 1'b1;
        #1;
        nxt();
        data_addr_ok = 1'b0;
        #1;
        chk("rw_wait_stall", 32'(stall_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rw_req", 32'(data_req), 32'd0);
        chk("rw_stall", 32'(stall_req), 32'd0);
        chk("rw_lv", 32'(load_valid), 32'd0);
        chk("rw_ldata", load_data, 32'h0);
        chk("rw_addr", data_addr, 32'h0);
        chk("rw_wr", 32'(data_wr), 32'd0);
        chk("rw_size", 32'(data_size), 32'd0);
`ifdef MEM_PERF_CNT_EN
        chk("rw_perf_stall", perf_stall_cycles, 32'd0);
        chk("rw_perf_access", perf_access_cnt, 32'd0);
`endif
        mem_req_valid = 1'b0;
        nxt();
        rst = 1'b1;
        nxt();
        chk("post_rst_stall", 32'(stall_req), 32'd0);
        chk("post_rst_req", 32'(data_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
